// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler: credit-based round-robin output arbiter over five VCs (N,S,E,W,L).
// Define VC_SCHED_PKT_LOCK_EN to add wormhole packet locking and flit-type checking.
module vc_output_scheduler #(
   parameter int CREDIT_MAX = 32,
   parameter int CW = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] vc_empty,
   input  logic [9:0] head_type,
   input  logic       link_ready,
   input  logic       credit_in_valid,
   input  logic [2:0] credit_in_vc,
   output logic       read_en,
   output logic [2:0] rr_select,
   output logic       out_valid,
   output logic [2:0] out_vc,
   output logic       credit_err,
   output logic       proto_err
);
   logic [4:0][CW-1:0] credit;
   logic [2:0] last_grant, winner, idx;
   logic [3:0] sum;
   logic [4:0] elig, inc, dec, at_max;
   logic       found;
   logic [1:0] wt;
`ifdef VC_SCHED_PKT_LOCK_EN
   localparam logic IDLE = 1'b0, LOCKED = 1'b1;
   logic       state;
   logic [2:0] lock_vc;
`endif
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         elig[i] = !vc_empty[i] && credit[i] != '0 && link_ready
`ifdef VC_SCHED_PKT_LOCK_EN
            && (state == IDLE || lock_vc == 3'(i))
`endif
            ;
         inc[i] = credit_in_valid && credit_in_vc == 3'(i);
         at_max[i] = credit[i] == CW'(CREDIT_MAX);
      end
   end
   // search starts one past the last grant and wraps 4 -> 0
   always_comb begin
      winner = 3'd7;
      found = 1'b0;
      wt = 2'b00;
      sum = '0;
      idx = '0;
      for (int k = 1; k <= 5; k++) begin
         sum = {1'b0, last_grant} + 4'(k);
         idx = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
         if (!found && elig[idx]) begin
            found = 1'b1;
            winner = idx;
            wt = head_type[{idx, 1'b0} +: 2];
         end
      end
   end
   assign read_en = found && reset;
   assign rr_select = read_en ? winner : 3'b111;
   always_comb begin
      for (int i = 0; i < 5; i++) dec[i] = read_en && winner == 3'(i);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) credit[i] <= CW'(CREDIT_MAX);
         last_grant <= 3'd4;
         out_valid <= 1'b0;
         out_vc <= 3'b000;
         credit_err <= 1'b0;
      end else begin
         for (int i = 0; i < 5; i++)
            credit[i] <= (inc[i] && !dec[i] && !at_max[i]) ? credit[i] + CW'(1) :
                         (dec[i] && !inc[i]) ? credit[i] - CW'(1) : credit[i];
         out_valid <= read_en;
         out_vc <= rr_select;
         credit_err <= credit_err | (credit_in_valid && credit_in_vc > 3'd4) | (|(inc & ~dec & at_max));
`ifdef VC_SCHED_PKT_LOCK_EN
         if (read_en && state == IDLE) last_grant <= winner;
`else
         if (read_en) last_grant <= winner;
`endif
      end
   end
`ifdef VC_SCHED_PKT_LOCK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         lock_vc <= 3'b000;
         proto_err <= 1'b0;
      end else if (read_en) begin
         if (state == IDLE) begin
            if (wt == 2'b01) begin
               state <= LOCKED;
               lock_vc <= winner;
            end else if (wt != 2'b11) proto_err <= 1'b1;
         end else begin
            if (wt == 2'b10) state <= IDLE;
            else if (wt[0]) proto_err <= 1'b1;
         end
      end
   end
`else
   // flit types carry no meaning without locking; the AND folds to constant 0
   assign proto_err = 1'b0 & (|wt);
`endif
endmodule

// File: tb/tb_vc_output_scheduler.sv
// tb_vc_output_scheduler: directed self-checking bench for vc_output_scheduler.
module tb_vc_output_scheduler;
`ifdef VC_SCHED_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif
   logic       clk = 1'b0, reset = 1'b0;
   logic [4:0] vc_empty = 5'h1f;
   logic [9:0] head_type = 10'h3ff;
   logic       link_ready = 1'b1, credit_in_valid = 1'b0;
   logic [2:0] credit_in_vc = 3'd0;
   logic       read_en, out_valid, credit_err, proto_err;
   logic [2:0] rr_select, out_vc;
   int n_cmp = 0, n_bad = 0, n;
   logic [2:0] exp_vc [4];
   logic [1:0] w_type [4];

   vc_output_scheduler dut (
      .clk(clk), .reset(reset), .vc_empty(vc_empty), .head_type(head_type),
      .link_ready(link_ready), .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
      .read_en(read_en), .rr_select(rr_select), .out_valid(out_valid), .out_vc(out_vc),
      .credit_err(credit_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] empt);
      reset = 1'b0;
      vc_empty = empt;
      head_type = 10'h3ff;
      link_ready = 1'b1;
      credit_in_valid = 1'b0;
      credit_in_vc = 3'd0;
      tick();
      reset = 1'b1;
   endtask

   task automatic count_grants(input int max, output int cnt);
      cnt = 0;
      repeat (max) begin
         #1;
         if (read_en) cnt++;
         tick();
      end
   endtask

   initial begin
      // reset state, with traffic pending to prove outputs are held off
      vc_empty = 5'b00000;
      tick();
      check("rst_read_en", read_en, 0);
      check("rst_rr_select", rr_select, 3'b111);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_vc", out_vc, 0);
      check("rst_credit_err", credit_err, 0);
      check("rst_proto_err", proto_err, 0);

      // N and E alternate
      do_reset(5'b11010);
      exp_vc = '{3'd0, 3'd2, 3'd0, 3'd2};
      for (int k = 0; k < 4; k++) begin
         #1;
         check("ne_read_en", read_en, 1);
         check("ne_rr_select", rr_select, exp_vc[k]);
         tick();
         check("ne_out_valid", out_valid, 1);
         check("ne_out_vc", out_vc, exp_vc[k]);
      end

      // E down to 5 credits, then grant and credit return together
      do_reset(5'b11011);
      count_grants(27, n);
      check("e_grants_27", n, 27);
      credit_in_valid = 1'b1;
      credit_in_vc = 3'd2;
      #1;
      check("e_same_cycle_grant", rr_select, 3'd2);
      tick();
      credit_in_valid = 1'b0;
      count_grants(10, n);
      check("e_credit_left", n, 5);
      #1;
      check("e_starved", read_en, 0);

      // S with 33 flits and 32 credits
      do_reset(5'b11101);
      count_grants(40, n);
      check("s_grants", n, 32);
      #1;
      check("s_stall", read_en, 0);
      check("s_stall_sel", rr_select, 3'b111);
      credit_in_valid = 1'b1;
      credit_in_vc = 3'd1;
      #1;
      check("s_ret_cycle", read_en, 0);
      tick();
      credit_in_valid = 1'b0;
      #1;
      check("s_regrant", read_en, 1);
      check("s_regrant_sel", rr_select, 3'd1);
      tick();
      check("s_regrant_out", out_valid, 1);
      check("s_regrant_vc", out_vc, 3'd1);
      #1;
      check("s_stall2", read_en, 0);

      // credit overflow on N
      do_reset(5'h1f);
      credit_in_valid = 1'b1;
      credit_in_vc = 3'd0;
      tick();
      credit_in_valid = 1'b0;
      #1;
      check("ovf_err", credit_err, 1);
      vc_empty = 5'b11110;
      count_grants(40, n);
      check("ovf_saturated", n, 32);
      check("ovf_sticky", credit_err, 1);

      // invalid credit VC code
      do_reset(5'h1f);
      #1;
      check("inv_err_clear", credit_err, 0);
      credit_in_valid = 1'b1;
      credit_in_vc = 3'b110;
      tick();
      credit_in_valid = 1'b0;
      #1;
      check("inv_err", credit_err, 1);
      vc_empty = 5'b00000;
      count_grants(200, n);
      check("inv_no_change", n, 160);

      // W packet head/body/tail with L always pending
      do_reset(5'b00111);
      w_type = '{2'b01, 2'b00, 2'b10, 2'b11};
      exp_vc = LOCK ? '{3'd3, 3'd3, 3'd3, 3'd4} : '{3'd3, 3'd4, 3'd3, 3'd4};
      for (int k = 0; k < 4; k++) begin
         head_type = {2'b11, w_type[k], 6'h3f};
         #1;
         check("lock_seq", rr_select, exp_vc[k]);
         tick();
      end
      check("lock_no_proto", proto_err, 0);

      // body flit granted outside a packet
      do_reset(5'b11110);
      head_type = 10'h3fc;
      tick();
      check("proto_body_idle", proto_err, LOCK);

      // reset mid-packet on S
      do_reset(5'b11101);
      head_type = 10'h3f7;
      tick();
      head_type = 10'h3f3;
      #1;
      check("mid_read_en", read_en, 1);
      check("mid_sel", rr_select, 3'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_read_en", read_en, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sel", rr_select, 3'b111);
      vc_empty = 5'b00000;
      head_type = 10'h3ff;
      tick();
      reset = 1'b1;
      #1;
      check("restart_at_n", rr_select, 3'd0);
      vc_empty = 5'b11110;
      count_grants(40, n);
      check("restart_credit", n, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
